// File: rtl/char_mem_sched.sv
// Time-slot scheduler for the shared character/font RAM.
// Each 8-pixel cell gives xslot 0/1 to the video fetch (char code, then glyph row).
// The remaining slots, or all slots while fetch is off, serve one queued CPU access.
module char_mem_sched #(
    parameter int unsigned           ADDR_WIDTH = 13,
    parameter logic [ADDR_WIDTH-1:0] FONT_BASE  = 13'd3088
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            xslot,
    input  logic [3:0]            font_row,
    input  logic                  video_fetch_en,
    input  logic [ADDR_WIDTH-1:0] video_char_addr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    input  logic                  cpu_rstrb,
    input  logic                  cpu_wstrb,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_rbusy,
    output logic                  cpu_wbusy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic [7:0]            font_bits,
    output logic                  font_hilite,
    output logic                  font_load
);

    typedef enum logic [2:0] {
        StIdle,
        StRdPend,
        StWrPend,
        StRdIssued,
        StRdDone
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [7:0]            lat_wdata_q, lat_wdata_d;
    logic                  hilite_pend_q;

    logic                  cpu_slot;
    logic [10:0]           glyph_row;
    logic [ADDR_WIDTH-1:0] font_addr;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [7:0]            issue_wdata;
    logic                  issue_we;

    assign cpu_slot  = ~video_fetch_en | (xslot >= 3'd2);
    // Glyph codes 31..127 land in the font region; the carry-out is dropped.
    assign glyph_row = {mem_rdata[6:0], font_row};
    assign font_addr = {{(ADDR_WIDTH-11){1'b0}}, glyph_row} + FONT_BASE;

    // CPU access FSM: next state, latches and the access issued this cycle.
    always_comb begin
        state_d     = state_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        issue_addr  = cpu_addr;
        issue_wdata = cpu_wdata;
        issue_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A write wins over a simultaneous read.
                if (cpu_wstrb) begin
                    if (cpu_slot) begin
                        issue_we = 1'b1;
                    end else begin
                        lat_addr_d  = cpu_addr;
                        lat_wdata_d = cpu_wdata;
                        state_d     = StWrPend;
                    end
                end else if (cpu_rstrb) begin
                    if (cpu_slot) begin
                        state_d = StRdIssued;
                    end else begin
                        lat_addr_d = cpu_addr;
                        state_d    = StRdPend;
                    end
                end
            end
            StWrPend: begin
                if (cpu_slot) begin
                    issue_we    = 1'b1;
                    issue_addr  = lat_addr_q;
                    issue_wdata = lat_wdata_q;
                    state_d     = StIdle;
                end
            end
            StRdPend: begin
                if (cpu_slot) begin
                    issue_addr = lat_addr_q;
                    state_d    = StRdIssued;
                end
            end
            StRdIssued: state_d = StRdDone;
            StRdDone:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // RAM port mux: video owns slots 0/1 while fetching, CPU otherwise.
    always_comb begin
        mem_addr  = issue_addr;
        mem_wdata = issue_wdata;
        // Reset gates the strobe so nothing is written while reset is held.
        mem_we    = issue_we & cpu_slot & ~reset;
        if (!cpu_slot) begin
            mem_addr = (xslot == 3'd0) ? video_char_addr : font_addr;
        end
    end

    // Busy flags seen by the CPU bus.
    always_comb begin
        cpu_rbusy = cpu_rstrb | (state_q == StRdPend) | (state_q == StRdIssued);
        cpu_wbusy = (cpu_wstrb & ~cpu_slot) | (state_q == StWrPend);
    end

    // CPU state, latched request and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            cpu_rdata   <= '0;
        end else begin
            state_q     <= state_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            if (state_q == StRdIssued) begin
                cpu_rdata <= {4{mem_rdata}};
            end
        end
    end

    // Video pipeline: code's bit 7 after slot 0 read, bitmap after slot 1 read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hilite_pend_q <= 1'b0;
            font_bits     <= '0;
            font_hilite   <= 1'b0;
            font_load     <= 1'b0;
        end else begin
            font_load <= video_fetch_en && (xslot == 3'd2);
            if (video_fetch_en && (xslot == 3'd1)) begin
                hilite_pend_q <= mem_rdata[7];
            end
            if (video_fetch_en && (xslot == 3'd2)) begin
                font_bits   <= mem_rdata;
                font_hilite <= hilite_pend_q;
            end
        end
    end

endmodule
